// File: rtl/arc4_key_search.sv
// Brute-force ARC4 key search controller: sweeps keys through an external
// arc4 core and reports the first key whose length-prefixed plaintext is printable.
module arc4_key_search #(
   parameter int               KEY_W     = 24,
   parameter logic [KEY_W-1:0] KEY_FIRST = '0,
   parameter int               KEY_STEP  = 1,
   parameter int               ADDR_W    = 8,
   parameter logic [7:0]       CHAR_LO   = 8'h20,
   parameter logic [7:0]       CHAR_HI   = 8'h7E
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   output logic              rdy,
   output logic              key_valid,
   output logic              key_found,
   output logic [KEY_W-1:0]  key,
   output logic              core_en,
   output logic [KEY_W-1:0]  core_key,
   input  logic              core_rdy,
   output logic [ADDR_W-1:0] pt_addr,
   input  logic [7:0]        pt_rddata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_RD_LEN,
      S_SCAN,
      S_NEXT,
      S_DONE
   } state_t;

   state_t              r_state;
   logic                r_rdy;
   logic                r_key_valid;
   logic                r_key_found;
   logic [KEY_W-1:0]    r_key;
   logic                r_core_en;
   logic [KEY_W-1:0]    r_core_key;
   logic [ADDR_W-1:0]   r_pt_addr;
   logic [7:0]          r_len;
   logic [7:0]          r_idx;
   logic                r_ph;

   logic [KEY_W:0]      w_sum;
   logic                w_byte_ok;
   logic                w_abort;

   // Extra top bit catches the carry that marks an exhausted key space
   assign w_sum     = {1'b0, r_core_key} + (KEY_W+1)'(KEY_STEP);
   assign w_byte_ok = (pt_rddata >= CHAR_LO) && (pt_rddata <= CHAR_HI);
   assign w_abort   = stop && (r_state != S_IDLE) && (r_state != S_DONE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_rdy       <= 1'b1;
         r_key_valid <= 1'b0;
         r_key_found <= 1'b0;
         r_key       <= '0;
         r_core_en   <= 1'b0;
         r_core_key  <= KEY_FIRST;
         r_pt_addr   <= '0;
         r_len       <= '0;
         r_idx       <= '0;
         r_ph        <= 1'b0;
      end else begin
         r_core_en <= 1'b0;
         if (w_abort) begin
            r_state     <= S_DONE;
            r_key_found <= 1'b0;
            r_key_valid <= 1'b1;
            r_rdy       <= 1'b1;
         end else begin
            unique case (r_state)
               S_IDLE, S_DONE: begin
                  if (start) begin
                     r_core_key  <= KEY_FIRST;
                     r_rdy       <= 1'b0;
                     r_key_valid <= 1'b0;
                     r_key_found <= 1'b0;
                     r_state     <= S_LAUNCH;
                  end
               end
               S_LAUNCH: begin
                  if (core_rdy) begin
                     r_core_en <= 1'b1;
                     r_state   <= S_WAIT_ACK;
                  end
               end
               S_WAIT_ACK: begin
                  if (!core_rdy) r_state <= S_WAIT_DONE;
               end
               S_WAIT_DONE: begin
                  if (core_rdy) begin
                     r_pt_addr <= '0;
                     r_ph      <= 1'b0;
                     r_state   <= S_RD_LEN;
                  end
               end
               // r_ph=0: address settles into the RAM; r_ph=1: data sampled
               S_RD_LEN: begin
                  if (!r_ph) begin
                     r_ph <= 1'b1;
                  end else begin
                     r_len <= pt_rddata;
                     if (pt_rddata == 8'd0) begin
                        r_key       <= r_core_key;
                        r_key_found <= 1'b1;
                        r_key_valid <= 1'b1;
                        r_rdy       <= 1'b1;
                        r_state     <= S_DONE;
                     end else begin
                        r_idx     <= 8'd1;
                        r_pt_addr <= ADDR_W'(1);
                        r_ph      <= 1'b0;
                        r_state   <= S_SCAN;
                     end
                  end
               end
               S_SCAN: begin
                  if (!r_ph) begin
                     r_ph <= 1'b1;
                  end else if (!w_byte_ok) begin
                     r_state <= S_NEXT;
                  end else if (r_idx == r_len) begin
                     r_key       <= r_core_key;
                     r_key_found <= 1'b1;
                     r_key_valid <= 1'b1;
                     r_rdy       <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_idx     <= r_idx + 8'd1;
                     r_pt_addr <= ADDR_W'(r_idx + 8'd1);
                     r_ph      <= 1'b0;
                  end
               end
               S_NEXT: begin
                  if (w_sum[KEY_W]) begin
                     r_key_found <= 1'b0;
                     r_key_valid <= 1'b1;
                     r_rdy       <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_core_key <= w_sum[KEY_W-1:0];
                     r_state    <= S_LAUNCH;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign rdy       = r_rdy;
   assign key_valid = r_key_valid;
   assign key_found = r_key_found;
   assign key       = r_key;
   assign core_en   = r_core_en;
   assign core_key  = r_core_key;
   assign pt_addr   = r_pt_addr;

endmodule
